// File: rtl/tape_arbiter.sv
// Tape RAM arbiter: the core owns the single RAM port by default, and host
// accesses steal one cycle each, spaced by a minimum number of core-owned cycles.
module tape_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CORE_GAP = 2
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_core_stall,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ack,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [15:0]       o_host_count
);

    localparam int unsigned GAP_W = 4;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_CORE = 2'd0,
        ST_HOST = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [CNT_W-1:0]  host_count_q, host_count_d;
    logic              host_ack_q, host_ack_d;
    logic              core_stall_q, core_stall_d;

    // Next-state, gap spacing, read capture and access counting
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        host_rdata_d = host_rdata_q;
        host_count_d = host_count_q;
        case (state_q)
            ST_CORE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (i_host_req) begin
                    state_d = ST_HOST;
                end
            end
            ST_HOST: begin
                // The access completes even if the request drops during HOST
                state_d = ST_ACK;
                gap_d   = GAP_W'(CORE_GAP - 1);
                if (!i_host_we) begin
                    host_rdata_d = i_ram_rdata;
                end
                if (host_count_q != '1) begin
                    host_count_d = host_count_q + CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_CORE;
            end
            default: begin
                state_d = ST_CORE;
            end
        endcase
        // Status outputs are registered copies of the state being entered
        core_stall_d = (state_d == ST_HOST);
        host_ack_d   = (state_d == ST_ACK);
    end

    // State and output registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_CORE;
            gap_q        <= '0;
            host_rdata_q <= '0;
            host_count_q <= '0;
            host_ack_q   <= 1'b0;
            core_stall_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            host_rdata_q <= host_rdata_d;
            host_count_q <= host_count_d;
            host_ack_q   <= host_ack_d;
            core_stall_q <= core_stall_d;
        end
    end

    // RAM port mux: host only during HOST, so a stalled core write never lands
    always_comb begin
        o_ram_we    = i_core_we;
        o_ram_addr  = i_core_addr;
        o_ram_wdata = i_core_wdata;
        if (state_q == ST_HOST) begin
            o_ram_we    = i_host_we;
            o_ram_addr  = i_host_addr;
            o_ram_wdata = i_host_wdata;
        end
    end

    assign o_core_rdata = i_ram_rdata;
    assign o_core_stall = core_stall_q;
    assign o_host_ack   = host_ack_q;
    assign o_host_rdata = host_rdata_q;
    assign o_host_count = host_count_q;

endmodule

// File: tb/tb_tape_arbiter.sv
// Directed self-checking bench for tape_arbiter with a behavioural tape RAM.
module tb_tape_arbiter;

    logic       clk;
    logic       rst_n;
    logic       core_we;
    logic [7:0] core_addr;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata;
    logic       core_stall;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [15:0] host_count;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    tape_arbiter #(.ADDR_W(8), .DATA_W(8), .CORE_GAP(2)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_core_we    (core_we),
        .i_core_addr  (core_addr),
        .i_core_wdata (core_wdata),
        .o_core_rdata (core_rdata),
        .o_core_stall (core_stall),
        .i_host_req   (host_req),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_ack   (host_ack),
        .o_host_rdata (host_rdata),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .o_host_count (host_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tape RAM: asynchronous read, synchronous write
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic core_write(input logic [7:0] a, input logic [7:0] d);
        core_we = 1'b1; core_addr = a; core_wdata = d;
        step();
        check_eq("core_wr_stall", 32'(core_stall), 32'd0);
        core_we = 1'b0;
    endtask

    // Holds a read request for 12 cycles, dropping it on the third ack
    task automatic held_reads(output int acks, output int stalls, output int at0,
                              output int at1, output int at2);
        acks = 0; stalls = 0; at0 = 0; at1 = 0; at2 = 0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (core_stall) stalls++;
            if (host_ack) begin
                if (acks == 0) at0 = k;
                if (acks == 1) at1 = k;
                if (acks == 2) at2 = k;
                acks++;
                if (acks == 3) host_req = 1'b0;
            end
        end
    endtask

    int acks, stalls, at0, at1, at2;
    logic [15:0] base;

    initial begin
        rst_n = 1'b0;
        core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
        #3;
        check_eq("rst_ack", 32'(host_ack), 32'd0);
        check_eq("rst_stall", 32'(core_stall), 32'd0);
        check_eq("rst_count", 32'(host_count), 32'd0);
        check_eq("rst_rdata", 32'(host_rdata), 32'd0);
        #4 rst_n = 1'b1;

        // Core-only writes with an idle host
        core_write(8'h03, 8'h5A);
        core_write(8'h10, 8'h77);
        core_write(8'h30, 8'h00);
        check_eq("core_mem3", 32'(mem[3]), 32'h5A);
        check_eq("core_rdata", 32'(core_rdata), 32'h00);

        // Single host read of 0x10
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        step();
        check_eq("rd_stall", 32'(core_stall), 32'd1);
        check_eq("rd_ack_early", 32'(host_ack), 32'd0);
        check_eq("rd_ram_addr", 32'(ram_addr), 32'h10);
        step();
        check_eq("rd_ack", 32'(host_ack), 32'd1);
        check_eq("rd_stall_off", 32'(core_stall), 32'd0);
        check_eq("rd_rdata", 32'(host_rdata), 32'h77);
        check_eq("rd_count", 32'(host_count), 32'd1);
        host_req = 1'b0;
        step();
        check_eq("rd_ack_pulse", 32'(host_ack), 32'd0);
        idle(3);

        // Host write collides with a held core write to the same address
        core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h11;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'hC3;
        step();
        check_eq("wr_stall", 32'(core_stall), 32'd1);
        check_eq("wr_ram_wdata", 32'(ram_wdata), 32'hC3);
        step();
        check_eq("wr_mem_host", 32'(mem[8'h20]), 32'hC3);
        check_eq("wr_ack", 32'(host_ack), 32'd1);
        check_eq("wr_rdata_kept", 32'(host_rdata), 32'h77);
        host_req = 1'b0;
        step();
        check_eq("wr_mem_core", 32'(mem[8'h20]), 32'h11);
        core_we = 1'b0;
        idle(3);

        // Held request: period of CORE_GAP+2 cycles
        base = host_count;
        held_reads(acks, stalls, at0, at1, at2);
        check_eq("held_acks", 32'(acks), 32'd3);
        check_eq("held_first_ack", 32'(at0), 32'd2);
        check_eq("held_space1", 32'(at1 - at0), 32'd4);
        check_eq("held_space2", 32'(at2 - at1), 32'd4);
        check_eq("held_stalls", 32'(stalls), 32'd3);
        check_eq("held_count", 32'(host_count - base), 32'd3);
        idle(3);

        // Reset asserted during a HOST write cycle
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'hEE;
        step();
        check_eq("rh_stall", 32'(core_stall), 32'd1);
        check_eq("rh_ram_we", 32'(ram_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rh_ack", 32'(host_ack), 32'd0);
        check_eq("rh_stall_off", 32'(core_stall), 32'd0);
        check_eq("rh_count", 32'(host_count), 32'd0);
        check_eq("rh_rdata", 32'(host_rdata), 32'd0);
        check_eq("rh_ram_we_off", 32'(ram_we), 32'd0);
        step();
        check_eq("rh_mem_kept", 32'(mem[8'h30]), 32'h00);
        check_eq("rh_no_ack", 32'(host_ack), 32'd0);

        // First grant on the first edge after reset release
        host_we = 1'b0; host_addr = 8'h10;
        #3 rst_n = 1'b1;
        step();
        check_eq("post_rst_stall", 32'(core_stall), 32'd1);
        step();
        check_eq("post_rst_ack", 32'(host_ack), 32'd1);
        check_eq("post_rst_rdata", 32'(host_rdata), 32'h77);
        check_eq("post_rst_count", 32'(host_count), 32'd1);
        host_req = 1'b0;
        idle(4);

        // Counter saturation
        force dut.host_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.host_count_q;
        #1;
        check_eq("sat_preload", 32'(host_count), 32'hFFFE);
        held_reads(acks, stalls, at0, at1, at2);
        check_eq("sat_acks", 32'(acks), 32'd3);
        check_eq("sat_count", 32'(host_count), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
